conv_window_scheduler: RTL and testbench

Sequences 3x3 convolution-window reads over one stored image frame for the YOLOv7 feature-extraction front end. On `start`, it walks every valid stride-1, no-padding window in raster order. For each window it emits the nine pixel addresses in row-major tap order (offsets 0, 1, 2, W, W+1, W+2, 2W, 2W+1, 2W+2) over a valid/ready handshake to the image-memory read port. It replaces the free-running tap FSM with a start/busy/done-controlled, back-pressurable scheduler.

---
 rtl/conv_sched_pkg.sv | 15 +
 rtl/window_tap_seq.sv | 91 +++++++++
 rtl/conv_window_scheduler.sv | 159 +++++++++++++++
 tb/tb_conv_window_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the 3x3 convolution window scheduler.
package conv_sched_pkg;

  localparam int unsigned KERNEL   = 3;
  localparam int unsigned NUM_TAPS = 9;
  localparam int unsigned TAP_W    = 4;
  localparam int unsigned KCOL_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/window_tap_seq.sv
// Tap counter for one 3x3 window: walks taps 0..8 and tracks the pixel offset
// from the window base using only adders (column step +1, row step +IMG_W).
module window_tap_seq
  import conv_sched_pkg::*;
#(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              finish,
  input  logic              advance,
  output logic [TAP_W-1:0]  tap_idx,
  output logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] offset_nxt_c,
  output logic              first,
  output logic              last
);

  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [KCOL_W-1:0] kcol_q, kcol_d;
  logic [ADDR_W-1:0] roff_q, roff_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic              first_q, first_d;
  logic              last_q, last_d;

  // Next tap/offset; start re-arms at tap 0, finish parks everything at zero.
  always_comb begin
    tap_d   = tap_q;
    kcol_d  = kcol_q;
    roff_d  = roff_q;
    off_d   = off_q;
    first_d = first_q;
    last_d  = last_q;
    if (start || finish) begin
      tap_d   = '0;
      kcol_d  = '0;
      roff_d  = '0;
      off_d   = '0;
      first_d = start;
      last_d  = 1'b0;
    end else if (advance) begin
      if (last_q) begin
        tap_d   = '0;
        kcol_d  = '0;
        roff_d  = '0;
        off_d   = '0;
        first_d = 1'b1;
        last_d  = 1'b0;
      end else begin
        tap_d   = tap_q + TAP_W'(1);
        first_d = 1'b0;
        last_d  = (tap_q == TAP_W'(NUM_TAPS - 2));
        if (kcol_q == KCOL_W'(KERNEL - 1)) begin
          kcol_d = '0;
          roff_d = roff_q + ADDR_W'(IMG_W);
          off_d  = roff_q + ADDR_W'(IMG_W);
        end else begin
          kcol_d = kcol_q + KCOL_W'(1);
          off_d  = off_q + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tap_q   <= '0;
      kcol_q  <= '0;
      roff_q  <= '0;
      off_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      tap_q   <= tap_d;
      kcol_q  <= kcol_d;
      roff_q  <= roff_d;
      off_q   <= off_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign tap_idx      = tap_q;
  assign offset       = off_q;
  assign offset_nxt_c = off_d;
  assign first        = first_q;
  assign last         = last_q;

endmodule

// File: rtl/conv_window_scheduler.sv
// Start/busy/done controlled scheduler issuing the nine tap addresses of every
// valid 3x3 stride-1 window of a frame, in raster order, over valid/ready.
module conv_window_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 640,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [TAP_W-1:0]  tap_idx,
  output logic              win_first,
  output logic              win_last,
  output logic [ADDR_W-1:0] win_col,
  output logic [ADDR_W-1:0] win_row
);

  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(IMG_W - KERNEL);
  localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(IMG_H - KERNEL);

  sched_state_e      state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              start_c;
  logic              fire_c;
  logic              win_end_c;
  logic              frame_end_c;
  logic [TAP_W-1:0]  seq_tap;
  logic [ADDR_W-1:0] seq_offset;
  logic [ADDR_W-1:0] seq_offset_nxt_c;
  logic              seq_first;
  logic              seq_last;

  assign start_c     = (state_q == ST_IDLE) && start;
  assign fire_c      = valid_q && addr_ready;
  assign win_end_c   = fire_c && seq_last;
  assign frame_end_c = win_end_c && (col_q == COL_MAX) && (row_q == ROW_MAX);

  window_tap_seq #(
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W)
  ) u_tap_seq (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start_c),
    .finish       (frame_end_c),
    .advance      (fire_c),
    .tap_idx      (seq_tap),
    .offset       (seq_offset),
    .offset_nxt_c (seq_offset_nxt_c),
    .first        (seq_first),
    .last         (seq_last)
  );

  // FSM plus window counters; the next address is precomputed on every fire.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          col_d   = '0;
          row_d   = '0;
          base_d  = '0;
          addr_d  = '0;
        end
      end
      ST_ISSUE: begin
        if (frame_end_c) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          done_d  = 1'b1;
          col_d   = '0;
          row_d   = '0;
          base_d  = '0;
          addr_d  = '0;
        end else if (fire_c) begin
          if (win_end_c) begin
            if (col_q == COL_MAX) begin
              col_d  = '0;
              row_d  = row_q + ADDR_W'(1);
              base_d = base_q + ADDR_W'(KERNEL);
            end else begin
              col_d  = col_q + ADDR_W'(1);
              base_d = base_q + ADDR_W'(1);
            end
          end
          addr_d = base_d + seq_offset_nxt_c;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
    end
  end

  // The registered address must always equal window base plus tap offset.
  assert property (@(posedge clk) disable iff (!reset_n)
    valid_q |-> (addr_q == base_q + seq_offset));

  assign busy       = busy_q;
  assign done       = done_q;
  assign addr_valid = valid_q;
  assign addr       = addr_q;
  assign tap_idx    = seq_tap;
  assign win_first  = seq_first;
  assign win_last   = seq_last;
  assign win_col    = col_q;
  assign win_row    = row_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Self-checking bench: three scheduler instances (4x4, 5x3, 11x7) checked
// against an address model derived directly from window/tap arithmetic.
module tb_conv_window_scheduler;

  localparam int unsigned AW = 19;
  localparam int NI = 3;
  localparam int IW [NI] = '{4, 5, 11};
  localparam int IH [NI] = '{4, 3, 7};

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start   [NI];
  logic          rdy     [NI];
  logic          busy    [NI];
  logic          done    [NI];
  logic          valid   [NI];
  logic          first   [NI];
  logic          last    [NI];
  logic [3:0]    tap     [NI];
  logic [AW-1:0] addr    [NI];
  logic [AW-1:0] wcol    [NI];
  logic [AW-1:0] wrow    [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_window_scheduler #(.IMG_W(4), .IMG_H(4), .ADDR_W(AW)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .addr_valid(valid[0]), .addr_ready(rdy[0]), .addr(addr[0]), .tap_idx(tap[0]),
    .win_first(first[0]), .win_last(last[0]), .win_col(wcol[0]), .win_row(wrow[0]));

  conv_window_scheduler #(.IMG_W(5), .IMG_H(3), .ADDR_W(AW)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .addr_valid(valid[1]), .addr_ready(rdy[1]), .addr(addr[1]), .tap_idx(tap[1]),
    .win_first(first[1]), .win_last(last[1]), .win_col(wcol[1]), .win_row(wrow[1]));

  conv_window_scheduler #(.IMG_W(11), .IMG_H(7), .ADDR_W(AW)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .addr_valid(valid[2]), .addr_ready(rdy[2]), .addr(addr[2]), .tap_idx(tap[2]),
    .win_first(first[2]), .win_last(last[2]), .win_col(wcol[2]), .win_row(wrow[2]));

  task automatic check_zero(input int k, input string tag);
    checks++;
    if (busy[k] !== 1'b0 || done[k] !== 1'b0 || valid[k] !== 1'b0 || addr[k] !== '0 ||
        tap[k] !== 4'd0 || first[k] !== 1'b0 || last[k] !== 1'b0 || wcol[k] !== '0 ||
        wrow[k] !== '0) begin
      errors++;
      $display("FAIL %s inst=%0d: busy=%b done=%b valid=%b addr=%0d tap=%0d first=%b last=%b col=%0d row=%0d, want all 0",
               tag, k, busy[k], done[k], valid[k], addr[k], tap[k], first[k], last[k], wcol[k], wrow[k]);
    end
  endtask

  // Runs one frame on instance k. mode: 0 ready high, 1 ready toggling, 2 random.
  // abort_at > 0 returns (mid-frame) once that many fires have been issued.
  task automatic run_frame(input int k, input int mode, input int abort_at, input bit poke,
                           output int fires, output int maxaddr, output int cycles);
    int w, h, total, idx, t, r, c, ea;
    bit go;
    w = IW[k]; h = IH[k];
    total = 9 * (w - 2) * (h - 2);
    idx = 0; fires = 0; maxaddr = 0; cycles = 0;
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    while (idx < total && cycles < 20 * total + 20) begin
      if (abort_at > 0 && idx == abort_at) begin
        rdy[k] = 1'b0;
        return;
      end
      t = idx % 9;
      r = (idx / 9) / (w - 2);
      c = (idx / 9) % (w - 2);
      ea = (r + t / 3) * w + c + t % 3;
      checks++;
      if (valid[k] !== 1'b1 || busy[k] !== 1'b1 || done[k] !== 1'b0 || addr[k] !== AW'(ea) ||
          tap[k] !== 4'(t) || wcol[k] !== AW'(c) || wrow[k] !== AW'(r) ||
          first[k] !== (t == 0) || last[k] !== (t == 8)) begin
        errors++;
        $display("FAIL tap inst=%0d idx=%0d: valid=%b busy=%b done=%b addr=%0d tap=%0d col=%0d row=%0d first=%b last=%b; want addr=%0d tap=%0d col=%0d row=%0d",
                 k, idx, valid[k], busy[k], done[k], addr[k], tap[k], wcol[k], wrow[k],
                 first[k], last[k], ea, t, c, r);
      end
      case (mode)
        0:       go = 1'b1;
        1:       go = (cycles % 2 == 0);
        default: go = ($urandom_range(0, 1) == 1);
      endcase
      rdy[k] = go;
      start[k] = poke && (cycles == 3);
      if (go) begin
        idx++;
        if (valid[k] === 1'b1) fires++;
        if (int'(addr[k]) > maxaddr) maxaddr = int'(addr[k]);
      end
      @(negedge clk);
      cycles++;
    end
    rdy[k] = 1'b0;
    checks++;
    if (idx < total) begin
      errors++;
      $display("FAIL timeout inst=%0d: fires=%0d want %0d", k, idx, total);
      return;
    end
    start[k] = poke;
    checks++;
    if (done[k] !== 1'b1 || busy[k] !== 1'b0 || valid[k] !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse inst=%0d: done=%b busy=%b valid=%b want 1 0 0", k, done[k], busy[k], valid[k]);
    end
    @(negedge clk);
    start[k] = 1'b0;
    checks++;
    if (done[k] !== 1'b0 || busy[k] !== 1'b0 || valid[k] !== 1'b0) begin
      errors++;
      $display("FAIL done_end inst=%0d: done=%b busy=%b valid=%b want 0 0 0", k, done[k], busy[k], valid[k]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      start[k] = 1'b0;
      rdy[k] = 1'b0;
    end
    #3;
    for (int k = 0; k < NI; k++) check_zero(k, "reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) check_zero(k, "idle_after_reset");
  endtask

  task automatic test_back_to_back();
    int f, m, cy;
    run_frame(0, 0, 0, 1'b0, f, m, cy);
    checks++;
    if (f != 36 || cy != 36 || m != 15) begin
      errors++;
      $display("FAIL back_to_back: fires=%0d cycles=%0d max=%0d want 36 36 15", f, cy, m);
    end
  endtask

  task automatic test_toggle_ready();
    int f, m, cy;
    run_frame(0, 1, 0, 1'b0, f, m, cy);
    checks++;
    if (f != 36 || cy != 71) begin
      errors++;
      $display("FAIL toggle_ready: fires=%0d cycles=%0d want 36 71", f, cy);
    end
  endtask

  task automatic test_narrow();
    int f, m, cy;
    run_frame(1, 0, 0, 1'b0, f, m, cy);
    checks++;
    if (f != 27 || m != 14) begin
      errors++;
      $display("FAIL narrow: fires=%0d max=%0d want 27 14", f, m);
    end
  endtask

  task automatic test_start_ignored();
    int f, m, cy;
    run_frame(0, 0, 0, 1'b1, f, m, cy);
    run_frame(0, 2, 0, 1'b0, f, m, cy);
    checks++;
    if (f != 36 || m != 15) begin
      errors++;
      $display("FAIL restart_after_done: fires=%0d max=%0d want 36 15", f, m);
    end
  endtask

  task automatic test_reset_mid_frame();
    int f, m, cy;
    bit saw_done;
    run_frame(0, 0, 17, 1'b0, f, m, cy);
    #2 reset_n = 1'b0;
    #1 check_zero(0, "reset_mid_frame");
    @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || busy[0] !== 1'b0 || valid[0] !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_idle: inst 0 left IDLE without start after reset");
    end
    run_frame(0, 0, 0, 1'b0, f, m, cy);
    checks++;
    if (f != 36) begin
      errors++;
      $display("FAIL reset_restart: fires=%0d want 36", f);
    end
  endtask

  task automatic test_random_ready();
    int f, m, cy;
    run_frame(2, 2, 0, 1'b0, f, m, cy);
    checks++;
    if (f != 405 || m != 76) begin
      errors++;
      $display("FAIL random_ready: fires=%0d max=%0d want 405 76", f, m);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_toggle_ready();
    test_narrow();
    test_start_ignored();
    test_reset_mid_frame();
    test_random_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
